// File: rtl/uart_tx_engine.sv
// rtl/uart_tx_engine.sv - UART serial transmit engine: 11-bit-time frame, selectable baud, parity.
module uart_tx_engine #(
  parameter int CLK_HZ = 100000000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       LOAD,
  input  logic [7:0] OUT_PORT,
  input  logic       EIGHT,
  input  logic       PEN,
  input  logic       OHEL,
  input  logic [3:0] BAUD,
  output logic       TX,
  output logic       TXRDY
);

  // Bit periods rounded to the nearest clock; 921600 and above clamp to the same divisor.
  localparam logic [18:0] DIV_300    = 19'((CLK_HZ + 150) / 300);
  localparam logic [18:0] DIV_1200   = 19'((CLK_HZ + 600) / 1200);
  localparam logic [18:0] DIV_2400   = 19'((CLK_HZ + 1200) / 2400);
  localparam logic [18:0] DIV_4800   = 19'((CLK_HZ + 2400) / 4800);
  localparam logic [18:0] DIV_9600   = 19'((CLK_HZ + 4800) / 9600);
  localparam logic [18:0] DIV_19200  = 19'((CLK_HZ + 9600) / 19200);
  localparam logic [18:0] DIV_38400  = 19'((CLK_HZ + 19200) / 38400);
  localparam logic [18:0] DIV_57600  = 19'((CLK_HZ + 28800) / 57600);
  localparam logic [18:0] DIV_115200 = 19'((CLK_HZ + 57600) / 115200);
  localparam logic [18:0] DIV_230400 = 19'((CLK_HZ + 115200) / 230400);
  localparam logic [18:0] DIV_460800 = 19'((CLK_HZ + 230400) / 460800);
  localparam logic [18:0] DIV_921600 = 19'((CLK_HZ + 460800) / 921600);

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  state_t      state_q, state_d;
  logic [18:0] bt_q, bt_d;
  logic [3:0]  bit_q, bit_d;
  logic [10:0] sh_q, sh_d;
  logic [3:0]  baud_q, baud_d;

  logic [18:0] div;
  logic        parity;
  logic        b7, b8;
  logic [10:0] frame;

  always_comb begin
    div = DIV_921600;
    case (baud_q)
      4'd0:    div = DIV_300;
      4'd1:    div = DIV_1200;
      4'd2:    div = DIV_2400;
      4'd3:    div = DIV_4800;
      4'd4:    div = DIV_9600;
      4'd5:    div = DIV_19200;
      4'd6:    div = DIV_38400;
      4'd7:    div = DIV_57600;
      4'd8:    div = DIV_115200;
      4'd9:    div = DIV_230400;
      4'd10:   div = DIV_460800;
      default: div = DIV_921600;
    endcase
  end

  assign parity = (^OUT_PORT[6:0]) ^ (EIGHT & OUT_PORT[7]) ^ OHEL;
  assign b7     = EIGHT ? OUT_PORT[7] : (PEN ? parity : 1'b1);
  assign b8     = (EIGHT & PEN) ? parity : 1'b1;
  assign frame  = {1'b1, b8, b7, OUT_PORT[6:0], 1'b0};

  always_comb begin
    state_d = state_q;
    bt_d    = bt_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    baud_d  = baud_q;
    case (state_q)
      S_IDLE: begin
        if (LOAD) begin
          baud_d  = BAUD;
          sh_d    = frame;
          bt_d    = '0;
          bit_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (bt_q == div - 19'd1) begin
          bt_d = '0;
          if (bit_q == 4'd10) begin
            bit_d   = '0;
            sh_d    = '1;
            state_d = S_IDLE;
          end else begin
            bit_d = bit_q + 4'd1;
            sh_d  = {1'b1, sh_q[10:1]};
          end
        end else begin
          bt_d = bt_q + 19'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      bt_q    <= '0;
      bit_q   <= '0;
      sh_q    <= '1;
      baud_q  <= '0;
    end else begin
      state_q <= state_d;
      bt_q    <= bt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      baud_q  <= baud_d;
    end
  end

  assign TX    = sh_q[0];
  assign TXRDY = (state_q == S_IDLE);

endmodule

// File: tb/tb_uart_tx_engine.sv
// tb/tb_uart_tx_engine.sv - directed self-checking bench for uart_tx_engine.
module tb_uart_tx_engine;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       LOAD;
  logic [7:0] OUT_PORT;
  logic       EIGHT, PEN, OHEL;
  logic [3:0] BAUD;
  logic       TX, TXRDY;

  int n_checks = 0;
  int n_pass   = 0;

  uart_tx_engine #(.CLK_HZ(100000000)) dut (
    .clk(clk), .reset_n(reset_n), .LOAD(LOAD), .OUT_PORT(OUT_PORT),
    .EIGHT(EIGHT), .PEN(PEN), .OHEL(OHEL), .BAUD(BAUD), .TX(TX), .TXRDY(TXRDY)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  // Called at a negedge; returns at the negedge right after the frame should have ended.
  task automatic send(input string tag, input logic [7:0] data, input logic e8, input logic pe,
                      input logic odd, input logic [3:0] baud, input logic [10:0] exp_bits,
                      input int n, input int busy_at);
    int bad_rdy;
    OUT_PORT = data; EIGHT = e8; PEN = pe; OHEL = odd; BAUD = baud; LOAD = 1'b1;
    @(posedge clk);
    bad_rdy = 0;
    for (int k = 0; k < 11; k++) begin
      int bad_tx;
      bad_tx = 0;
      for (int c = 0; c < n; c++) begin
        @(negedge clk);
        LOAD = 1'b0;
        if (TX !== exp_bits[k]) bad_tx++;
        if (TXRDY !== 1'b0) bad_rdy++;
        if (k * n + c == busy_at) begin
          LOAD = 1'b1; OUT_PORT = 8'hFF; EIGHT = ~EIGHT; BAUD = 4'd0;
        end
      end
      check($sformatf("%s_bit%0d_badcycles", tag, k), bad_tx, 0);
    end
    check($sformatf("%s_txrdy_low_badcycles", tag), bad_rdy, 0);
    @(negedge clk);
    check($sformatf("%s_txrdy_end", tag), TXRDY, 1'b1);
    check($sformatf("%s_tx_end", tag), TX, 1'b1);
  endtask

  task automatic idle_check(input string tag, input int cycles);
    int bad;
    bad = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (TX !== 1'b1 || TXRDY !== 1'b1) bad++;
    end
    check(tag, bad, 0);
  endtask

  initial begin
    reset_n = 1'b0; LOAD = 1'b1; OUT_PORT = 8'h00; EIGHT = 1'b1; PEN = 1'b0; OHEL = 1'b0;
    BAUD = 4'd11;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("reset_tx_%0d", i), TX, 1'b1);
      check($sformatf("reset_txrdy_%0d", i), TXRDY, 1'b1);
    end
    LOAD = 1'b0;
    reset_n = 1'b1;
    idle_check("post_reset_idle", 20);

    send("8n1_55", 8'h55, 1'b1, 1'b0, 1'b0, 4'd11, 11'h6AA, 109, -1);
    idle_check("gap1", 5);
    send("7e1_41", 8'h41, 1'b0, 1'b1, 1'b0, 4'd11, 11'h682, 109, -1);
    idle_check("gap2", 5);
    send("7o1_41", 8'h41, 1'b0, 1'b1, 1'b1, 4'd11, 11'h782, 109, -1);
    idle_check("gap3", 5);
    send("8e1_03", 8'h03, 1'b1, 1'b1, 1'b0, 4'd11, 11'h406, 109, -1);
    idle_check("gap4", 5);
    send("baud10_55", 8'h55, 1'b1, 1'b0, 1'b0, 4'd10, 11'h6AA, 217, -1);
    idle_check("gap5", 5);

    send("busy_55", 8'h55, 1'b1, 1'b0, 1'b0, 4'd11, 11'h6AA, 109, 300);
    idle_check("busy_no_second_frame", 300);

    // Abort during D3 (bit index 4) of an A5 frame
    OUT_PORT = 8'hA5; EIGHT = 1'b1; PEN = 1'b0; OHEL = 1'b0; BAUD = 4'd11; LOAD = 1'b1;
    @(posedge clk);
    @(negedge clk);
    LOAD = 1'b0;
    repeat (4 * 109 + 50) @(negedge clk);
    check("abort_tx_in_d3", TX, 1'b0);
    reset_n = 1'b0;
    @(negedge clk);
    check("abort_tx", TX, 1'b1);
    check("abort_txrdy", TXRDY, 1'b1);
    reset_n = 1'b1;
    idle_check("abort_idle", 50);
    send("after_abort_a5", 8'hA5, 1'b1, 1'b0, 1'b0, 4'd11, 11'h74A, 109, -1);

    // Back-to-back: next LOAD lands on the first edge where TXRDY is high; BAUD=15 clamps
    send("b2b_first", 8'h41, 1'b0, 1'b1, 1'b0, 4'd15, 11'h682, 109, -1);
    send("b2b_second", 8'hA5, 1'b1, 1'b0, 1'b0, 4'd15, 11'h74A, 109, -1);
    idle_check("final_idle", 20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_engine.md
# uart_tx_engine

Serial transmit engine for the UART peripheral bank. It sits directly downstream of the address decoder: one decoded write strobe, bit 0 of the bank-0 write strobe vector, acts as this block's `LOAD`. A strobe accepted while the engine is idle captures the 8-bit processor output data and frame configuration. The engine then shifts out a fixed 11-bit-time asynchronous frame at the selected baud rate and raises `TXRDY` when it can accept the next byte.

## Interface
- `CLK_HZ`, 100000000: system clock frequency in Hz. The divisor table below is valid for this value only.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset_n`  in  1  reset, synchronous and active-low.
- `LOAD`  in  1  single-cycle write strobe from the address decoder.
- `OUT_PORT`  in  8  processor output data byte.
- `EIGHT`  in  1  1 = 8 data bits; 0 = 7 data bits.
- `PEN`  in  1  parity enable.
- `OHEL`  in  1  parity sense: 1 = odd, 0 = even.
- `BAUD`  in  4  baud-rate select.
- `TX`  out  1  serial line output; idle high.
- `TXRDY`  out  1  1 = idle and ready for `LOAD`.

## Operation
- **States:**
  - IDLE: `TXRDY`=1, `TX`=1.
  - SHIFT: `TXRDY`=0.
- **Accepting a load:**
  - `LOAD`=1 in IDLE: register `OUT_PORT`, `EIGHT`, `PEN`, `OHEL` and `BAUD`, load the frame, then go to SHIFT.
  - `LOAD`=1 in SHIFT: ignored entirely; no data or configuration changes.
  - Configuration input changes during SHIFT have no effect.
- **Frame order on the line:** 11 bit times, in this order: start (0), D0..D6, B7, B8, B9.
  - B7 = `EIGHT` ? D7 : (`PEN` ? P : 1).
  - B8 = (`EIGHT` & `PEN`) ? P : 1.
  - B9 = 1.
- **Parity:**
  - P = XOR of the transmitted data bits (D0..D6, plus D7 when `EIGHT`=1), inverted when `OHEL`=1.
  - Unused trailing bits are stop bits (1).
- **Bit period:** divisor N per `BAUD`, in clocks:
  - 0 = 333333 (300 baud)
  - 1 = 83333 (1200)
  - 2 = 41667 (2400)
  - 3 = 20833 (4800)
  - 4 = 10417 (9600)
  - 5 = 5208 (19200)
  - 6 = 2604 (38400)
  - 7 = 1736 (57600)
  - 8 = 868 (115200)
  - 9 = 434 (230400)
  - 10 = 217 (460800)
  - 11 = 109 (921600)
  - 12–15 clamp to 109.
- **Counters:**
  - Bit-time counter: 19 bits, counts 0..N-1, wraps to 0.
  - Bit counter: 4 bits, counts 0..10.
  - Frame ends when the bit counter reaches 10 and the bit-time counter reaches N-1; the engine then returns to IDLE.
- **Shift register:** 11 bits, LSB drives `TX`, shifts right with 1 fill at each bit-time wrap. `TX` is registered; no combinational path from inputs to `TX`.

## Timing
- **Reset:** `reset_n` sampled low at an edge → after that edge `TX`=1, `TXRDY`=1, state IDLE, both counters 0, shift register all 1s. This includes reset mid-frame: the frame is aborted with no glitch-low on `TX`.
- **Load timing:** `LOAD` sampled high at edge t0 in IDLE → from t0+1, `TX`=0 (start bit) and `TXRDY`=0.
- **Bit boundaries:** each bit holds exactly N clocks. Bit k is driven from t0+1+k·N.
- **Frame end:** `TXRDY` returns to 1 at t0+1+11·N, i.e. it is low for exactly 11·N cycles.
- **Back-to-back:** `LOAD` sampled at the first edge where `TXRDY`=1 starts the next start bit on the following cycle. No minimum idle gap is enforced.
- **Reset priority:** reset has priority over `LOAD` in the same cycle.

## Test plan
- **Reset:** hold `reset_n`=0 for 3 cycles with `LOAD`=1 → `TX`=1, `TXRDY`=1 throughout and after release; nothing transmitted.
- **8N1 frame:** `BAUD`=11 (N=109), `EIGHT`=1, `PEN`=0, `OUT_PORT`=8'h55, one `LOAD` pulse → `TX` = 0,1,0,1,0,1,0,1,0,1,1, each bit 109 cycles. `TXRDY` low for exactly 1199 cycles.
- **7E1 frame:** `EIGHT`=0, `PEN`=1, `OHEL`=0, `OUT_PORT`=8'h41 → bits 0,1,0,0,0,0,0,1,0,1,1. With `OHEL`=1 → bit 8 becomes 1.
- **Load while busy:** mid-frame, pulse `LOAD` with `OUT_PORT`=8'hFF and toggle `EIGHT`/`BAUD` → current frame unchanged; no second frame follows.
- **Reset mid-frame:** `reset_n` low during D3 → `TX`=1, `TXRDY`=1 on the next cycle. A following `LOAD` of 8'hA5 sends a clean 8'hA5 frame.
- **Back-to-back and clamp:** `LOAD` asserted on the cycle `TXRDY` rises → the next start bit follows with no gap. `BAUD`=15 → bit period 109 cycles.
